// File: rtl/regfile_multiport_if.sv
// Request/response bundle for regfile_multiport: write port, packed read ports and clear-sweep
// control. The master drives requests; the slave (the register file) returns data and status.
interface regfile_multiport_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned NUM_RD = 2
);
    logic                       in_ctrl_regwrt;
    logic [ADDR_W-1:0]          in_rd;
    logic [DATA_W-1:0]          in_rdval;
    logic [NUM_RD*ADDR_W-1:0]   in_rs;
    logic [NUM_RD*DATA_W-1:0]   out_rsval;
    logic                       in_clr_req;
    logic                       out_clr_busy;
    logic                       out_clr_done;

    modport master (
        output in_ctrl_regwrt, in_rd, in_rdval, in_rs, in_clr_req,
        input  out_rsval, out_clr_busy, out_clr_done
    );

    modport slave (
        input  in_ctrl_regwrt, in_rd, in_rdval, in_rs, in_clr_req,
        output out_rsval, out_clr_busy, out_clr_done
    );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with registered reads, optional write bypass, optional
// hardwired zero entry and a clear-sweep engine that zeroes one entry per cycle.
module regfile_multiport #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_multiport_if.slave bus
);
    localparam int unsigned  DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(DEPTH - 1);

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_cfg
        $error("regfile_multiport: NUM_RD must be in 1..4");
    end

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    state_e                   state_q;
    logic [ADDR_W:0]          idx_q;
    logic                     busy_q;
    logic                     done_q;
    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DATA_W-1:0]        regs_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rsval_q;
    logic [NUM_RD*DATA_W-1:0] rsval_d;
    logic                     wr_en;
    logic                     sweep_en;

    assign sweep_en = (state_q == StSweep);
    assign wr_en    = bus.in_ctrl_regwrt && !(ZERO_REG && (bus.in_rd == '0));

    // Write is applied after the sweep clear so a same-edge write to the swept entry wins.
    always_comb begin
        regs_d = regs_q;
        if (sweep_en) begin
            regs_d[idx_q[ADDR_W-1:0]] = '0;
        end
        if (wr_en) begin
            regs_d[bus.in_rd] = bus.in_rdval;
        end
    end

    // Bypass reads the post-edge contents; otherwise the pre-edge contents.
    always_comb begin
        rsval_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (ZERO_REG && (bus.in_rs[k*ADDR_W +: ADDR_W] == '0)) begin
                rsval_d[k*DATA_W +: DATA_W] = '0;
            end else if (BYPASS) begin
                rsval_d[k*DATA_W +: DATA_W] = regs_d[bus.in_rs[k*ADDR_W +: ADDR_W]];
            end else begin
                rsval_d[k*DATA_W +: DATA_W] = regs_q[bus.in_rs[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                regs_q[i] <= '0;
            end else begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsval_q <= '0;
        end else begin
            rsval_q <= rsval_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_clr_req) begin
                        state_q <= StSweep;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StSweep: begin
                    if (idx_q == LastIdx) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.out_rsval    = rsval_q;
    assign bus.out_clr_busy = busy_q;
    assign bus.out_clr_done = done_q;
endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: two configurations driven in lockstep (2 ports with bypass,
// 4 ports without bypass but with a hardwired zero entry) against an array-based reference.
module tb_regfile_multiport;
    logic        clk;
    logic        rst_n;
    logic        we;
    logic [5:0]  rd;
    logic [31:0] wd;
    logic        req;
    logic [5:0]  rs [4];

    int checks;
    int failures;

    regfile_multiport_if #(.DATA_W(32), .ADDR_W(6), .NUM_RD(2)) ifa ();
    regfile_multiport_if #(.DATA_W(32), .ADDR_W(6), .NUM_RD(4)) ifb ();

    assign ifa.in_ctrl_regwrt = we;
    assign ifa.in_rd          = rd;
    assign ifa.in_rdval       = wd;
    assign ifa.in_rs          = {rs[1], rs[0]};
    assign ifa.in_clr_req     = req;
    assign ifb.in_ctrl_regwrt = we;
    assign ifb.in_rd          = rd;
    assign ifb.in_rdval       = wd;
    assign ifb.in_rs          = {rs[3], rs[2], rs[1], rs[0]};
    assign ifb.in_clr_req     = req;

    regfile_multiport #(
        .DATA_W(32), .ADDR_W(6), .NUM_RD(2), .BYPASS(1'b1), .ZERO_REG(1'b0)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa.slave)
    );

    regfile_multiport #(
        .DATA_W(32), .ADDR_W(6), .NUM_RD(4), .BYPASS(1'b0), .ZERO_REG(1'b1)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arrays plus a sweep phase (0 idle, 1 sweeping, 2 done) and position.
    logic [31:0] ma [64];
    logic [31:0] mb [64];
    int          m_phase;
    int          m_pos;
    logic        e_busy;
    logic        e_done;
    logic [31:0] ea [2];
    logic [31:0] eb [4];

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        m_phase = 0;
        m_pos   = 0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] na [64];
        logic [31:0] nb [64];
        na = ma;
        nb = mb;
        if (m_phase == 1) begin
            na[m_pos] = '0;
            nb[m_pos] = '0;
        end
        if (we) begin
            na[rd] = wd;
            if (rd != 0) nb[rd] = wd;
        end
        for (int p = 0; p < 2; p++) ea[p] = na[rs[p]];
        for (int p = 0; p < 4; p++) eb[p] = (rs[p] == 0) ? 32'h0 : mb[rs[p]];
        if (m_phase == 0) begin
            if (req) begin
                m_phase = 1;
                m_pos   = 0;
                e_busy  = 1'b1;
            end
        end else if (m_phase == 1) begin
            if (m_pos == 63) begin
                m_phase = 2;
                e_busy  = 1'b0;
                e_done  = 1'b1;
            end else begin
                m_pos = m_pos + 1;
            end
        end else begin
            m_phase = 0;
            e_done  = 1'b0;
        end
        ma = na;
        mb = nb;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_busy", {31'h0, ifa.out_clr_busy}, {31'h0, e_busy});
        chk("a_done", {31'h0, ifa.out_clr_done}, {31'h0, e_done});
        chk("b_busy", {31'h0, ifb.out_clr_busy}, {31'h0, e_busy});
        chk("b_done", {31'h0, ifb.out_clr_done}, {31'h0, e_done});
        for (int p = 0; p < 2; p++)
            chk($sformatf("a_rs%0d", p), ifa.out_rsval[p*32 +: 32], ea[p]);
        for (int p = 0; p < 4; p++)
            chk($sformatf("b_rs%0d", p), ifb.out_rsval[p*32 +: 32], eb[p]);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        we  = 1'b0;
        rd  = '0;
        wd  = '0;
        req = 1'b0;
        for (int p = 0; p < 4; p++) rs[p] = '0;
    endtask

    task automatic read_all();
        idle_inputs();
        for (int i = 0; i < 64; i++) begin
            for (int p = 0; p < 4; p++) rs[p] = 6'((i + p * 17) % 64);
            step();
        end
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_a_busy"}, {31'h0, ifa.out_clr_busy}, 32'h0);
        chk({tag, "_a_done"}, {31'h0, ifa.out_clr_done}, 32'h0);
        chk({tag, "_b_busy"}, {31'h0, ifb.out_clr_busy}, 32'h0);
        chk({tag, "_a_rsval_lo"}, ifa.out_rsval[31:0], 32'h0);
        chk({tag, "_a_rsval_hi"}, ifa.out_rsval[63:32], 32'h0);
        chk({tag, "_b_rsval_hi"}, ifb.out_rsval[127:96], 32'h0);
    endtask

    int busy_cnt;
    int done_cnt;
    int done_at;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check_reset_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Every entry reads zero after reset.
        read_all();

        // Write then read on the next cycle.
        idle_inputs();
        we = 1'b1; rd = 6'd5; wd = 32'hDEADBEEF;
        step();
        idle_inputs();
        rs[0] = 6'd5;
        step();
        chk("plan_rd5_a", ifa.out_rsval[31:0], 32'hDEADBEEF);
        chk("plan_rd5_b", ifb.out_rsval[31:0], 32'hDEADBEEF);

        // Same-edge write and read of entry 7.
        idle_inputs();
        we = 1'b1; rd = 6'd7; wd = 32'h55; rs[1] = 6'd7;
        step();
        chk("plan_bypass_a", ifa.out_rsval[63:32], 32'h55);
        chk("plan_nobypass_b", ifb.out_rsval[63:32], 32'h0);

        // Hardwired zero entry (b only) versus ordinary entry 1.
        idle_inputs();
        we = 1'b1; rd = 6'd0; wd = 32'h1234;
        step();
        idle_inputs();
        step();
        chk("plan_zero_b", ifb.out_rsval[31:0], 32'h0);
        chk("plan_zero_a", ifa.out_rsval[31:0], 32'h1234);
        we = 1'b1; rd = 6'd1; wd = 32'h1234;
        step();
        idle_inputs();
        rs[0] = 6'd1;
        step();
        chk("plan_r1_b", ifb.out_rsval[31:0], 32'h1234);

        // Randomised traffic, including occasional sweep requests.
        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom_range(0, 1));
            rd  = 6'($urandom_range(0, 63));
            wd  = $urandom;
            req = ($urandom_range(0, 59) == 0);
            for (int p = 0; p < 4; p++) rs[p] = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) rs[1] = rd;
            step();
        end
        idle_inputs();
        for (int n = 0; n < 70 && m_phase != 0; n++) step();

        // Fill, then sweep with a mid-sweep re-request and two writes.
        for (int i = 0; i < 64; i++) begin
            we = 1'b1; rd = 6'(i); wd = 32'(i + 100);
            step();
        end
        idle_inputs();
        req = 1'b1;
        step();
        busy_cnt = ifa.out_clr_busy ? 1 : 0;
        done_cnt = 0;
        done_at  = -1;
        for (int s = 1; s <= 70; s++) begin
            idle_inputs();
            req = (s == 5);
            if (s == 11) begin
                we = 1'b1; rd = 6'd60; wd = 32'hBB;
            end
            if (s == 41) begin
                we = 1'b1; rd = 6'd40; wd = 32'hAA;
            end
            step();
            if (ifa.out_clr_busy) busy_cnt++;
            if (ifa.out_clr_done) begin
                done_cnt++;
                done_at = s;
            end
        end
        chk("plan_busy_cycles", 32'(busy_cnt), 32'd64);
        chk("plan_done_count", 32'(done_cnt), 32'd1);
        chk("plan_done_cycle", 32'(done_at), 32'd64);
        idle_inputs();
        rs[0] = 6'd40; rs[1] = 6'd60; rs[2] = 6'd40; rs[3] = 6'd60;
        step();
        chk("plan_sweep_w40_a", ifa.out_rsval[31:0], 32'hAA);
        chk("plan_sweep_w60_a", ifa.out_rsval[63:32], 32'h0);
        chk("plan_sweep_w40_b", ifb.out_rsval[95:64], 32'hAA);
        chk("plan_sweep_w60_b", ifb.out_rsval[127:96], 32'h0);
        read_all();

        // Reset in the middle of a sweep, between clock edges.
        for (int i = 0; i < 64; i++) begin
            we = 1'b1; rd = 6'(i); wd = 32'(i * 3 + 1);
            rs[0] = 6'(i); rs[1] = 6'(63 - i);
            step();
        end
        idle_inputs();
        req = 1'b1;
        step();
        idle_inputs();
        rs[0] = 6'd50; rs[1] = 6'd51; rs[2] = 6'd52; rs[3] = 6'd53;
        for (int s = 0; s < 20; s++) step();
        chk("pre_abort_busy", {31'h0, ifa.out_clr_busy}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_zero("abort");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 50; s++) step();
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
